tempsensor_sim_bank: RTL

//  Parametrised bank of NUM_CH simulated temperature sensors for core-control verification.
//  - Each channel steps between T_MIN and T_MAX as a sawtooth or a triangle waveform.
//  - A prescaled tick sets the update rate; a test port injects values into any channel.
//  - Per-channel over-temperature alarms use hysteresis.

---
 rtl/tempsensor_sim_bank_if.sv | 27 ++
 rtl/tempsensor_sim_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tempsensor_sim_bank_if.sv
// Bus bundle for the simulated temperature sensor bank: control/inject
// inputs and the sampled temperature, strobe, alarm and counter outputs.
interface tempsensor_sim_bank_if #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 8
);
    logic                    enable;
    logic                    load_en;
    logic [3:0]              load_ch;
    logic [WIDTH-1:0]        load_val;
    logic [NUM_CH*WIDTH-1:0] temp_flat;
    logic                    temp_valid;
    logic [NUM_CH-1:0]       alarm;
    logic [15:0]             sample_cnt;

    // Stimulus side: drives control/inject, observes sensor outputs.
    modport master (
        output enable, load_en, load_ch, load_val,
        input  temp_flat, temp_valid, alarm, sample_cnt
    );

    // Sensor bank side.
    modport slave (
        input  enable, load_en, load_ch, load_val,
        output temp_flat, temp_valid, alarm, sample_cnt
    );
endinterface

// File: rtl/tempsensor_sim_bank.sv
// Bank of simulated temperature sensors. A shared prescaler produces update
// ticks; each channel walks a sawtooth or triangle between T_MIN and T_MAX,
// can be overwritten through the inject port, and raises a hysteretic
// over-temperature alarm.

// One sensor channel: waveform state, inject override and alarm flag.
module tempsensor_sim_ch #(
    parameter int WIDTH    = 8,
    parameter int T_MIN    = 30,
    parameter int T_MAX    = 90,
    parameter int STEP     = 1,
    parameter int MODE     = 0,
    parameter int START    = 30,
    parameter int ALARM_HI = 80,
    parameter int ALARM_LO = 70
) (
    input  logic             tempclk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] temp,
    output logic             alarm
);
    // One extra bit so cur+STEP never wraps, even for injected values near 2^WIDTH.
    localparam int EW = WIDTH + 1;
    localparam logic [EW-1:0]    E_STEP  = EW'(STEP);
    localparam logic [EW-1:0]    E_MIN   = EW'(T_MIN);
    localparam logic [EW-1:0]    E_MAX   = EW'(T_MAX);
    // cur-STEP >= T_MIN (signed) is the same as cur >= T_MIN+STEP for unsigned cur.
    localparam logic [EW-1:0]    E_DN    = EW'(T_MIN + STEP);
    localparam logic [WIDTH-1:0] W_START = WIDTH'(START);
    localparam logic [WIDTH-1:0] W_HI    = WIDTH'(ALARM_HI);
    localparam logic [WIDTH-1:0] W_LO    = WIDTH'(ALARM_LO);

    logic          dir_up;
    logic          nxt_dir;
    logic [EW-1:0] cur;
    logic [EW-1:0] up_sum;
    logic [EW-1:0] dn_dif;
    logic [EW-1:0] nxt_e;
    logic          up_ok;
    logic          dn_ok;
    logic          unused_top;

    assign cur        = {1'b0, temp};
    assign up_sum     = cur + E_STEP;
    assign dn_dif     = cur - E_STEP;
    assign up_ok      = (up_sum <= E_MAX);
    assign dn_ok      = (cur >= E_DN);
    // Every selected next value is <= max(T_MAX, cur), so the top bit is always 0.
    assign unused_top = nxt_e[WIDTH];

    // Next waveform value and direction for a tick.
    always_comb begin
        nxt_e   = cur;
        nxt_dir = dir_up;
        if (MODE == 0) begin
            nxt_e   = up_ok ? up_sum : E_MIN;
            nxt_dir = 1'b1;
        end else if (dir_up) begin
            if (up_ok) begin
                nxt_e = up_sum;
            end else begin
                nxt_dir = 1'b0;
                nxt_e   = dn_ok ? dn_dif : E_MIN;
            end
        end else begin
            if (dn_ok) begin
                nxt_e = dn_dif;
            end else begin
                nxt_dir = 1'b1;
                nxt_e   = up_ok ? up_sum : E_MAX;
            end
        end
    end

    // Channel value/direction: inject wins over a tick; inject restarts upward.
    always_ff @(posedge tempclk or posedge rst) begin
        if (rst) begin
            temp   <= W_START;
            dir_up <= 1'b1;
        end else if (load) begin
            temp   <= load_val;
            dir_up <= 1'b1;
        end else if (tick) begin
            temp   <= nxt_e[WIDTH-1:0];
            dir_up <= nxt_dir;
        end
    end

    // Hysteretic alarm sampled from the current value (one cycle behind it).
    always_ff @(posedge tempclk or posedge rst) begin
        if (rst) begin
            alarm <= 1'b0;
        end else if (temp >= W_HI) begin
            alarm <= 1'b1;
        end else if (temp <= W_LO) begin
            alarm <= 1'b0;
        end
    end
endmodule

module tempsensor_sim_bank #(
    parameter int NUM_CH     = 3,
    parameter int WIDTH      = 8,
    parameter int T_MIN      = 30,
    parameter int T_MAX      = 90,
    parameter int STEP       = 1,
    parameter int START_BASE = 30,
    parameter int START_INC  = 10,
    parameter int MODE       = 0,
    parameter int PRESCALE   = 1,
    parameter int ALARM_HI   = 80,
    parameter int ALARM_LO   = 70
) (
    input  logic                  tempclk,
    input  logic                  rst,
    tempsensor_sim_bank_if.slave  bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    // Reject parameter sets the channel arithmetic does not cover.
    if (NUM_CH < 1 || NUM_CH > 16 || PRESCALE < 1 || STEP < 1 ||
        STEP > T_MAX - T_MIN || ALARM_LO >= ALARM_HI ||
        START_BASE + (NUM_CH - 1) * START_INC > T_MAX) begin : g_bad_params
        $error("tempsensor_sim_bank: illegal parameter combination");
    end

    logic [PW-1:0]                 pcnt;
    logic                          tick;
    logic [NUM_CH-1:0][WIDTH-1:0]  temps;
    logic [NUM_CH-1:0]             alarms;

    assign tick = bus.enable && (pcnt == P_LAST);

    // Prescaler: runs only while enabled, wraps to 0 on the tick cycle.
    always_ff @(posedge tempclk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (bus.enable) begin
            pcnt <= tick ? '0 : pcnt + PW'(1);
        end
    end

    // Update strobe and tick counter, aligned with the new channel values.
    always_ff @(posedge tempclk or posedge rst) begin
        if (rst) begin
            bus.temp_valid <= 1'b0;
            bus.sample_cnt <= '0;
        end else begin
            bus.temp_valid <= tick;
            if (tick) begin
                bus.sample_cnt <= bus.sample_cnt + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic load;
        // An out-of-range load_ch matches no channel and is dropped.
        assign load = bus.load_en && (bus.load_ch == 4'(i));

        tempsensor_sim_ch #(
            .WIDTH    (WIDTH),
            .T_MIN    (T_MIN),
            .T_MAX    (T_MAX),
            .STEP     (STEP),
            .MODE     (MODE),
            .START    (START_BASE + i * START_INC),
            .ALARM_HI (ALARM_HI),
            .ALARM_LO (ALARM_LO)
        ) u_ch (
            .tempclk  (tempclk),
            .rst      (rst),
            .tick     (tick),
            .load     (load),
            .load_val (bus.load_val),
            .temp     (temps[i]),
            .alarm    (alarms[i])
        );
    end

    assign bus.temp_flat = temps;
    assign bus.alarm     = alarms;
endmodule
